// File: rtl/bus_arbiter.sv
// Round-robin owner of a registered shared bus: hold limit per tenure while others wait,
// and one dead turnaround cycle on every handover.
module bus_arbiter #(
  parameter int N        = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4,
  localparam int OW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] wdata,
  output logic [N-1:0]    gnt,
  output logic [OW-1:0]   owner,
  output logic [DW-1:0]   bus,
  output logic            bus_valid
);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_d;
  logic [OW-1:0]   owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      cnt_inc;
  logic [DW-1:0]   bus_d;
  logic            bus_valid_d;
  logic            found;
  logic [OW-1:0]   win;
  logic [OW-1:0]   cand;
  logic            others;

  // First requester after the last owner, wrapping modulo N
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = OW'((int'(last_q) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign others  = |(req & ~({{(N-1){1'b0}}, 1'b1} << owner));
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt;
    owner_d     = owner;
    last_d      = last_q;
    cnt_d       = cnt_q;
    bus_d       = bus;
    bus_valid_d = 1'b0;
    case (state_q)
      IDLE, TURN: begin
        gnt_d = '0;
        if (found) begin
          state_d      = OWN;
          gnt_d[win]   = 1'b1;
          owner_d      = win;
          cnt_d        = '0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (!req[owner]) begin
          state_d = TURN;
          gnt_d   = '0;
          last_d  = owner;
        end else begin
          bus_d       = wdata[int'(owner)*DW +: DW];
          bus_valid_d = 1'b1;
          // With nobody waiting the limit simply restarts instead of forcing a gap
          if (cnt_inc == 8'(MAX_HOLD)) begin
            if (others) begin
              state_d = TURN;
              gnt_d   = '0;
              last_d  = owner;
            end else begin
              cnt_d = '0;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= IDLE;
      gnt       <= '0;
      owner     <= '0;
      last_q    <= OW'(N - 1);
      cnt_q     <= '0;
      bus       <= '0;
      bus_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt       <= gnt_d;
      owner     <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      bus       <= bus_d;
      bus_valid <= bus_valid_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random checks of bus_arbiter against a tenure-level reference model.
module tb_bus_arbiter;
  localparam int N        = 4;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;

  logic            clk = 1'b0;
  logic            rstb;
  logic [N-1:0]    req;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [1:0]      owner;
  logic [DW-1:0]   bus;
  logic            bus_valid;

  int total  = 0;
  int passed = 0;

  // Model: current holder (-1 = nobody), round-robin pointer, beats in tenure
  int            m_holder;
  int            m_ptr;
  int            m_beats;
  int            m_owner;
  logic [DW-1:0] m_bus;
  logic          m_bv;

  bus_arbiter #(.N(N), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rstb(rstb), .req(req), .wdata(wdata),
    .gnt(gnt), .owner(owner), .bus(bus), .bus_valid(bus_valid)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag);
    logic [N-1:0] eg;
    eg = (m_holder >= 0) ? (N'(1) << m_holder) : '0;
    checkValue({tag, ".gnt"}, 32'(gnt), 32'(eg));
    checkValue({tag, ".owner"}, 32'(owner), 32'(m_owner));
    checkValue({tag, ".bus"}, 32'(bus), 32'(m_bus));
    checkValue({tag, ".bus_valid"}, 32'(bus_valid), 32'(m_bv));
    checkValue({tag, ".onehot"}, 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic modelReset();
    m_holder = -1;
    m_ptr    = N - 1;
    m_beats  = 0;
    m_owner  = 0;
    m_bus    = '0;
    m_bv     = 1'b0;
  endtask

  task automatic modelStep();
    int h;
    int j;
    h = m_holder;
    if (h >= 0 && req[h]) begin
      m_bus = wdata[h*DW +: DW];
      m_bv  = 1'b1;
    end else begin
      m_bv = 1'b0;
    end
    if (h >= 0) begin
      if (!req[h]) begin
        m_ptr    = h;
        m_holder = -1;
      end else begin
        m_beats++;
        if (m_beats == MAX_HOLD) begin
          if ((req & ~(N'(1) << h)) != '0) begin
            m_ptr    = h;
            m_holder = -1;
          end else begin
            m_beats = 0;
          end
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        j = (m_ptr + k) % N;
        if (m_holder < 0 && req[j]) begin
          m_holder = j;
          m_owner  = j;
          m_beats  = 0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N*DW-1:0] d);
    req   = r;
    wdata = d;
  endtask

  // Called at a negedge: drive, predict the next edge, then check one cycle later
  task automatic cycle(input string tag, input logic [N-1:0] r, input logic [N*DW-1:0] d);
    applyStimulus(r, d);
    if (rstb) modelStep();
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    logic [N*DW-1:0] d;
    rstb = 1'b1;
    applyStimulus('0, '0);
    #2 rstb = 1'b0;
    modelReset();
    #1 checkOutput("reset_async");
    @(negedge clk);
    repeat (3) cycle("in_reset", N'($urandom), $urandom);

    rstb = 1'b1;
    cycle("release", 4'b1111, $urandom);
    checkValue("release.first_gnt", 32'(gnt), 32'h1);
    repeat (3) cycle("drain", '0, $urandom);

    // Lone burst: no rotation gap when nobody else is waiting
    for (int j = 0; j < 7; j++) begin
      d = $urandom;
      d[2*DW +: DW] = 8'h10 + 8'((j > 0) ? j - 1 : 0);
      cycle("lone", 4'b0100, d);
      checkValue("lone.gnt", 32'(gnt), 32'h4);
      if (j > 0) begin
        checkValue("lone.bus", 32'(bus), 32'h10 + 32'(j - 1));
        checkValue("lone.valid", 32'(bus_valid), 32'd1);
      end
    end
    repeat (3) cycle("drain", '0, $urandom);

    // Contention: requester 0 wins, holds MAX_HOLD beats, one dead cycle, then 1
    for (int j = 0; j < 6; j++) begin
      cycle("contend", 4'b0011, $urandom);
      if (j < 4)       checkValue("contend.gnt0", 32'(gnt), 32'h1);
      else if (j == 4) checkValue("contend.turn", 32'(gnt), 32'h0);
      else             checkValue("contend.gnt1", 32'(gnt), 32'h2);
    end
    repeat (3) cycle("drain", '0, $urandom);

    repeat (40) cycle("full", 4'b1111, $urandom);
    repeat (3) cycle("drain", '0, $urandom);

    // Early release with requester 3 pending
    cycle("early", 4'b0001, $urandom);
    checkValue("early.gnt0", 32'(gnt), 32'h1);
    cycle("early", 4'b1001, $urandom);
    cycle("early", 4'b1001, $urandom);
    checkValue("early.beat2", 32'(bus_valid), 32'd1);
    cycle("early", 4'b1000, $urandom);
    checkValue("early.drop_gnt", 32'(gnt), 32'h0);
    checkValue("early.drop_valid", 32'(bus_valid), 32'd0);
    cycle("early", 4'b1000, $urandom);
    checkValue("early.gnt3", 32'(gnt), 32'h8);
    checkValue("early.turn_valid", 32'(bus_valid), 32'd0);
    repeat (3) cycle("drain", '0, $urandom);

    // Reset in the middle of the third beat
    cycle("midrst", 4'b0001, $urandom);
    cycle("midrst", 4'b0001, $urandom);
    cycle("midrst", 4'b0001, $urandom);
    applyStimulus(4'b0001, $urandom);
    #2 rstb = 1'b0;
    modelReset();
    #1 checkOutput("midrst_async");
    checkValue("midrst.gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    repeat (2) cycle("in_reset", N'($urandom), $urandom);
    rstb = 1'b1;
    cycle("rerelease", 4'b0111, $urandom);
    checkValue("rerelease.gnt", 32'(gnt), 32'h1);

    repeat (300) cycle("random", N'($urandom), $urandom);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares one registered 8-bit bus between N requesters with a per-owner hold limit and a forced one-cycle turnaround. Sits in front of the shared `bus` net: requesters drive their `wdata` slice, and the arbiter selects the owner, registers the winning data onto `bus` and flags valid beats to downstream `dff`/mux logic.

## Interface

- `N`, 4, number of requesters, 2..16.
- `DW`, 8, data width of each requester slice and of `bus`.
- `MAX_HOLD`, 4, maximum beats per tenure while another requester is waiting, 1..255.
- `clk`  in  1  clock; all state changes on its posedge.
- `rstb`  in  1  asynchronous active-low reset.
- `req`  in  N  request / beat-valid per requester.
- `wdata`  in  N*DW  requester i data in bits `[i*DW +: DW]`.
- `gnt`  out  N  one-hot grant (registered), all-zero when no owner.
- `owner`  out  max(1,clog2(N))  index of current/last owner (registered).
- `bus`  out  DW  registered shared-bus data.
- `bus_valid`  out  1  `bus` carries a beat accepted in the previous cycle.

## Operation

- Reset values: state IDLE, `gnt`=0, `owner`=0, `bus`=0, `bus_valid`=0, beat count=0, round-robin pointer `last`=N-1.
- Beat: a cycle in which `gnt[i] & req[i]`. The requester must hold `wdata` slice i stable for that cycle. At the closing edge, `bus` is loaded with slice i, `bus_valid` is set to 1 and the count increments. In every non-beat cycle `bus_valid` is set to 0 and `bus` holds its value.
- States:
  - IDLE: `gnt`=0. If any `req` is high, choose the first requester with `req` high, searching `last+1, last+2, ...` modulo N. Then go to OWN, setting `gnt`/`owner` to the winner and count=0. Otherwise stay in IDLE.
  - OWN: `gnt[owner]`=1.
    - If `req[owner]`=0: no beat; go to TURN.
    - Else a beat occurs. If the new count equals `MAX_HOLD`:
      - another `req` is high in that cycle: go to TURN.
      - no other `req` is high: count=0 and stay in OWN (no rotation, no gap).
    - Otherwise stay in OWN.
  - TURN: exactly one cycle with `gnt`=0 and no beat; `last`<=`owner`. Then arbitrate exactly as IDLE does, using the updated `last`. The result is OWN if any `req` is high, else IDLE.
- `owner` keeps its last value in IDLE and TURN.
- A requester that drops and re-raises `req` in the same tenure loses the grant on the drop.
- `rstb` low at any time clears all state and outputs immediately, independent of `clk`. Arbitration after release starts from requester 0.
- `gnt` is never multi-hot. No beat is ever accepted from a non-owner.

## Timing

- Grant latency from IDLE: `req` high in cycle t gives `gnt` in cycle t+1. The first beat is possible in t+1, and its data appears on `bus` with `bus_valid` in t+2.
- Data latency is one cycle from beat to `bus`/`bus_valid`.
- Handover costs one dead cycle (TURN). The next owner's `gnt` rises 2 cycles after the last beat of the previous owner.
- With all N requesting continuously, each rotation is N*(MAX_HOLD+1) cycles.
- The arbitration decision uses `req` sampled in the deciding cycle (IDLE/TURN/last beat). Requests raised later are considered at the next decision point.

## Test plan

- Reset: drive `rstb`=0 with random `req` → `gnt`=0, `owner`=0, `bus`=0, `bus_valid`=0. After release with `req`=4'b1111 → `gnt`=4'b0001 on the next cycle.
- Lone burst: `req[2]` high for 6 cycles with data 0x10..0x15, others low (N=4, MAX_HOLD=4):
  - `gnt`=4'b0100 for 6 consecutive cycles with no TURN gap.
  - `bus` shows 0x10..0x15 with `bus_valid`=1, one cycle delayed.
- Contention: `req[0]` and `req[1]` raised together from IDLE → requester 0 gets 4 beats, then one cycle `gnt`=0, then `gnt`=4'b0010.
- Full load: all `req` held high for 40 cycles → grant order 0,1,2,3,0,1,… with 4 beats each and one dead cycle between tenures. Assert one-hot `gnt` every cycle.
- Early release: the owner drops `req` after 2 beats while `req[3]` is pending → TURN next cycle, then `gnt`=4'b1000. `bus_valid` is 0 in the drop cycle and in TURN.
- Reset mid-burst: pull `rstb` low in the middle of a cycle during the 3rd beat → outputs clear before the next edge. After release, the pointer restarts and requester 0 wins if requesting.
